led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED-bar frame generator for the LED display module. On every frame-step strobe it advances a WIDTH-bit pattern in one of four selectable animations: fill/empty bar, bouncing dot, rotating dot, blink. It sits between the frame-rate divider, which supplies the strobe, and the LED output pins. It also reports completion of each animation period.

## Interface
Parameters:
- WIDTH, 16, number of LEDs; legal range 2..32.
- RESET_MODE, 0, animation mode loaded at reset (0..3).
- MSB_FIRST, 1, 1: patterns grow from led[WIDTH-1]; 0: output bit-reversed (led[i] driven from internal bit WIDTH-1-i).

Ports:
- clk, in, 1, single system clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- fc, in, 1, frame-step strobe; each cycle sampled high is one step.
- en, in, 1, step enable; fc is ignored while en=0.
- mode, in, 2, requested mode: 0 FILL, 1 SCAN, 2 ROTATE, 3 BLINK.
- led, out, WIDTH, current frame (registered).
- wrap, out, 1, one-cycle pulse marking the end of an animation period.
- cur_mode, out, 2, mode currently running (registered).

## Operation
- Internal state: frame register f[WIDTH-1:0], direction bit dir (0 = FWD, 1 = BACK), cur_mode. A step occurs on any cycle with fc=1 and en=1. All state is unchanged on non-step cycles.
- Mode change: at a step where mode != cur_mode, the step is consumed as a restart:
  - cur_mode <= mode, f <= 0, dir <= FWD, wrap stays 0.
  - mode is sampled only at steps; changes between steps take effect at the next step.
- FILL, period 2*WIDTH steps:
  - dir=FWD: if f is all ones, dir <= BACK and f <= f<<1; else f <= {1'b1, f[WIDTH-1:1]}.
  - dir=BACK: if f == 0, dir <= FWD and f <= MSB one-hot; else f <= f<<1.
  - wrap=1 on the step that loads f=0.
- SCAN (bouncing dot), period 2*WIDTH-2 steps after first load:
  - f == 0: f <= MSB one-hot, dir <= FWD, no wrap.
  - dir=FWD: if f[0], dir <= BACK and f <= f<<1; else f <= f>>1.
  - dir=BACK: if f[WIDTH-1], dir <= FWD and f <= f>>1; else f <= f<<1.
  - wrap=1 on the step whose result is MSB one-hot while the previous f != 0.
- ROTATE, period WIDTH:
  - f == 0: f <= MSB one-hot.
  - otherwise f <= {f[0], f[WIDTH-1:1]}.
  - wrap=1 when the loaded value is MSB one-hot and the previous f != 0.
- BLINK, period 2: f <= (f == 0) ? all ones : 0. wrap=1 on the step that loads 0.
- Robustness: any f value not reachable in the current mode recovers via that mode's rules. An arbitrary f in SCAN/ROTATE with multiple bits set simply shifts; no lock-up.

## Timing
- Reset (rst_n=0, asynchronous): f=0, led=0 (MSB_FIRST-mapped), dir=FWD, wrap=0, cur_mode=RESET_MODE. Reset release is synchronous to clk; the first step may occur on the first edge after release.
- Latency: a step sampled on edge N is visible on led from edge N (registered output, 1-cycle fc-to-led).
- wrap is high for exactly the cycle following the wrapping step edge, then returns to 0 unless the next cycle is also a wrapping step.
- fc held high steps every cycle. There is no internal rate limiting.
- en=0 with fc=1: no change, wrap=0.
- Reset asserted mid-animation returns all outputs to reset values immediately, regardless of clk.

## Test plan
- WIDTH=4, RESET_MODE=0, en=1, 9 fc pulses -> led 1000,1100,1110,1111,1110,1100,1000,0000,1000; wrap only coincident with 0000.
- WIDTH=4, mode=1 from reset (first step restarts to 0), then 8 steps -> 1000,0100,0010,0001,0010,0100,1000(wrap),0100.
- WIDTH=4, mode=2, 6 steps after the restart step -> 1000,0100,0010,0001,1000(wrap),0100. With MSB_FIRST=0, the same sequence appears bit-reversed on led.
- Mid-FILL at led=1110: change mode to 3 between steps, and check led is unchanged until the next fc. Next step -> led=0000, cur_mode=3, wrap=0. Following steps -> 1111, 0000(wrap).
- fc=1 with en=0 for 5 cycles -> led frozen. Pulse rst_n low mid-cycle at led=1100 -> led=0, wrap=0, cur_mode=RESET_MODE without a clock edge.
- WIDTH=32, FILL, fc held high 64 cycles -> returns to 0 with exactly one wrap pulse at cycle 64.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED-bar frame generator.
// Each frame-step strobe advances a WIDTH-bit pattern in one of four
// animations (fill/empty bar, bouncing dot, rotating dot, blink) and
// flags the end of every animation period with a one-cycle wrap pulse.
// A step that arrives with a different requested mode restarts the
// animation from an empty frame instead of advancing it.

module led_pattern_gen #(
   parameter int WIDTH      = 16,
   parameter int RESET_MODE = 0,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fc,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] led,
   output logic             wrap,
   output logic [1:0]       cur_mode
);

   typedef enum logic [1:0] {
      MODE_FILL   = 2'd0,
      MODE_SCAN   = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_FWD  = 1'b0,
      DIR_BACK = 1'b1
   } dir_t;

   localparam logic [1:0]       RESET_MODE_BITS = RESET_MODE[1:0];
   localparam mode_t            RESET_MODE_E    = mode_t'(RESET_MODE_BITS);
   localparam logic [WIDTH-1:0] MSB_ONE         = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES        = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZERO        = {WIDTH{1'b0}};

   logic [WIDTH-1:0] f_q, f_d;
   dir_t             dir_q, dir_d;
   mode_t            cur_mode_q, cur_mode_d;
   logic             wrap_q, wrap_d;

   logic             step;
   mode_t            req_mode;

   assign step     = fc & en;
   assign req_mode = mode_t'(mode);

   // Next-frame computation: a step either restarts on a mode change or applies the running mode's rule
   always_comb begin
      f_d        = f_q;
      dir_d      = dir_q;
      cur_mode_d = cur_mode_q;
      wrap_d     = 1'b0;

      if (step) begin
         if (req_mode != cur_mode_q) begin
            cur_mode_d = req_mode;
            f_d        = ALL_ZERO;
            dir_d      = DIR_FWD;
         end else begin
            case (cur_mode_q)
               MODE_FILL: begin
                  if (dir_q == DIR_FWD) begin
                     if (f_q == ALL_ONES) begin
                        dir_d = DIR_BACK;
                        f_d   = f_q << 1;
                     end else begin
                        f_d = {1'b1, f_q[WIDTH-1:1]};
                     end
                  end else begin
                     if (f_q == ALL_ZERO) begin
                        dir_d = DIR_FWD;
                        f_d   = MSB_ONE;
                     end else begin
                        f_d = f_q << 1;
                     end
                  end
                  wrap_d = (f_d == ALL_ZERO);
               end

               MODE_SCAN: begin
                  if (f_q == ALL_ZERO) begin
                     f_d   = MSB_ONE;
                     dir_d = DIR_FWD;
                  end else if (dir_q == DIR_FWD) begin
                     if (f_q[0]) begin
                        dir_d = DIR_BACK;
                        f_d   = f_q << 1;
                     end else begin
                        f_d = f_q >> 1;
                     end
                  end else begin
                     if (f_q[WIDTH-1]) begin
                        dir_d = DIR_FWD;
                        f_d   = f_q >> 1;
                     end else begin
                        f_d = f_q << 1;
                     end
                  end
                  wrap_d = (f_q != ALL_ZERO) && (f_d == MSB_ONE);
               end

               MODE_ROTATE: begin
                  if (f_q == ALL_ZERO) begin
                     f_d = MSB_ONE;
                  end else begin
                     f_d = {f_q[0], f_q[WIDTH-1:1]};
                  end
                  wrap_d = (f_q != ALL_ZERO) && (f_d == MSB_ONE);
               end

               MODE_BLINK: begin
                  f_d    = (f_q == ALL_ZERO) ? ALL_ONES : ALL_ZERO;
                  wrap_d = (f_d == ALL_ZERO);
               end

               default: begin
                  f_d = f_q;
               end
            endcase
         end
      end
   end

   // State registers; reset clears the frame and reloads the power-up mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q        <= ALL_ZERO;
         dir_q      <= DIR_FWD;
         cur_mode_q <= RESET_MODE_E;
         wrap_q     <= 1'b0;
      end else begin
         f_q        <= f_d;
         dir_q      <= dir_d;
         cur_mode_q <= cur_mode_d;
         wrap_q     <= wrap_d;
      end
   end

   // Pin mapping: either straight through or bit-reversed so the bar grows from led[0]
   always_comb begin
      led = ALL_ZERO;
      for (int i = 0; i < WIDTH; i++) begin
         if (MSB_FIRST != 0) begin
            led[i] = f_q[i];
         end else begin
            led[i] = f_q[WIDTH-1-i];
         end
      end
   end

   assign wrap     = wrap_q;
   assign cur_mode = cur_mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed bench for led_pattern_gen.
// Three instances share one stimulus: a 4-bit MSB-first bar, a 4-bit
// bit-reversed bar and a 32-bit bar.

module tb_led_pattern_gen;

   logic        clk;
   logic        rst_n;
   logic        fc;
   logic        en;
   logic [1:0]  mode;

   logic [3:0]  led4;
   logic        wrap4;
   logic [1:0]  cur_mode4;
   logic [3:0]  led4r;
   logic        wrap4r;
   logic [1:0]  cur_mode4r;
   logic [31:0] led32;
   logic        wrap32;
   logic [1:0]  cur_mode32;

   int total;
   int bad;

   led_pattern_gen #(.WIDTH(4), .RESET_MODE(0), .MSB_FIRST(1)) u_w4 (
      .clk(clk), .rst_n(rst_n), .fc(fc), .en(en), .mode(mode),
      .led(led4), .wrap(wrap4), .cur_mode(cur_mode4)
   );

   led_pattern_gen #(.WIDTH(4), .RESET_MODE(0), .MSB_FIRST(0)) u_w4r (
      .clk(clk), .rst_n(rst_n), .fc(fc), .en(en), .mode(mode),
      .led(led4r), .wrap(wrap4r), .cur_mode(cur_mode4r)
   );

   led_pattern_gen #(.WIDTH(32), .RESET_MODE(0), .MSB_FIRST(1)) u_w32 (
      .clk(clk), .rst_n(rst_n), .fc(fc), .en(en), .mode(mode),
      .led(led32), .wrap(wrap32), .cur_mode(cur_mode32)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Synchronous-release reset pulse; leaves the bench at posedge+1
   task automatic applyReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      fc    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One frame step: fc high across exactly one rising edge
   task automatic applyStimulus();
      fc = 1'b1;
      @(posedge clk);
      #1;
      fc = 1'b0;
   endtask

   logic [3:0] fill_exp [9] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b1000};
   logic       fill_wrap [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
   logic [3:0] scan_exp [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                4'b0010, 4'b0100, 4'b1000, 4'b0100};
   logic       scan_wrap [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   logic [3:0] rot_exp  [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
   logic [3:0] rot_rexp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
   logic       rot_wrap [6] = '{0, 0, 0, 0, 1, 0};

   // Directed sequence covering every animation, mode change, enable gating and reset
   initial begin
      int wrap_count;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      fc    = 1'b0;
      en    = 1'b1;
      mode  = 2'd0;

      #12;
      checkOutput("reset_led",      32'(led4),      32'h0);
      checkOutput("reset_wrap",     32'(wrap4),     32'h0);
      checkOutput("reset_cur_mode", 32'(cur_mode4), 32'h0);
      checkOutput("reset_led32",    led32,          32'h0);

      applyReset();

      $display("[TB] fill sequence");
      for (int i = 0; i < 9; i++) begin
         applyStimulus();
         checkOutput($sformatf("fill_led_%0d", i),  32'(led4),  32'(fill_exp[i]));
         checkOutput($sformatf("fill_wrap_%0d", i), 32'(wrap4), 32'(fill_wrap[i]));
      end
      @(posedge clk);
      #1;
      checkOutput("fill_wrap_idle", 32'(wrap4), 32'h0);

      $display("[TB] scan sequence");
      applyReset();
      mode = 2'd1;
      applyStimulus();
      checkOutput("scan_restart_led",  32'(led4),      32'h0);
      checkOutput("scan_restart_mode", 32'(cur_mode4), 32'd1);
      checkOutput("scan_restart_wrap", 32'(wrap4),     32'h0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         checkOutput($sformatf("scan_led_%0d", i),  32'(led4),  32'(scan_exp[i]));
         checkOutput($sformatf("scan_wrap_%0d", i), 32'(wrap4), 32'(scan_wrap[i]));
      end

      $display("[TB] rotate sequence");
      applyReset();
      mode = 2'd2;
      applyStimulus();
      checkOutput("rot_restart_led", 32'(led4), 32'h0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         checkOutput($sformatf("rot_led_%0d", i),   32'(led4),   32'(rot_exp[i]));
         checkOutput($sformatf("rot_ledr_%0d", i),  32'(led4r),  32'(rot_rexp[i]));
         checkOutput($sformatf("rot_wrap_%0d", i),  32'(wrap4),  32'(rot_wrap[i]));
      end

      $display("[TB] mode change mid fill");
      applyReset();
      mode = 2'd0;
      repeat (3) applyStimulus();
      checkOutput("chg_pre_led", 32'(led4), 32'b1110);
      @(posedge clk);
      #1;
      mode = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("chg_hold_led",  32'(led4),      32'b1110);
      checkOutput("chg_hold_mode", 32'(cur_mode4), 32'd0);
      applyStimulus();
      checkOutput("chg_restart_led",  32'(led4),      32'b0000);
      checkOutput("chg_restart_mode", 32'(cur_mode4), 32'd3);
      checkOutput("chg_restart_wrap", 32'(wrap4),     32'h0);
      applyStimulus();
      checkOutput("blink_on_led",  32'(led4),  32'b1111);
      checkOutput("blink_on_wrap", 32'(wrap4), 32'h0);
      applyStimulus();
      checkOutput("blink_off_led",  32'(led4),  32'b0000);
      checkOutput("blink_off_wrap", 32'(wrap4), 32'h1);

      $display("[TB] enable gating and async reset");
      applyReset();
      mode = 2'd0;
      repeat (2) applyStimulus();
      checkOutput("gate_pre_led", 32'(led4), 32'b1100);
      en = 1'b0;
      fc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("gate_led_%0d", i),  32'(led4),  32'b1100);
         checkOutput($sformatf("gate_wrap_%0d", i), 32'(wrap4), 32'h0);
      end
      fc = 1'b0;
      en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_led",  32'(led4),      32'h0);
      checkOutput("async_rst_wrap", 32'(wrap4),     32'h0);
      checkOutput("async_rst_mode", 32'(cur_mode4), 32'd0);
      #3;
      rst_n = 1'b1;

      $display("[TB] 32-bit fill with fc held high");
      applyReset();
      mode       = 2'd0;
      wrap_count = 0;
      fc         = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         @(posedge clk);
         #1;
         if (wrap32) wrap_count++;
         if (c == 32) checkOutput("w32_full_led", led32, 32'hFFFF_FFFF);
         if (c == 63) checkOutput("w32_c63_led", led32, 32'h8000_0000);
      end
      fc = 1'b0;
      checkOutput("w32_end_led",    led32,             32'h0);
      checkOutput("w32_end_wrap",   32'(wrap32),       32'h1);
      checkOutput("w32_wrap_count", 32'(wrap_count),   32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
